// File: rtl/scaler_sequencer_if.sv
// scaler_sequencer_if: sample stream from the scaler sequencer to the
// face-detection stage. The master presents a registered XYZ sample with
// valid/last; the slave returns ready.
interface scaler_sequencer_if;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_z;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output out_x, out_y, out_z, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_x, out_y, out_z, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/scaler_sequencer.sv
// scaler_sequencer: frame-level controller for the image scaler.
// Arms on start, waits for the camera frame origin, strobes the scaler write
// address on every sampled pixel while capturing, then streams the stored
// XYZ samples out over a valid/ready interface.
// Optional feature macro: SEQ_TIMEOUT_EN adds a CAPTURE watchdog and the
// sticky err_timeout output.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for start
// ARM      | waiting for cam_captured at column 0 / row 0
// CAPTURE  | writing sampled pixels, wr_cnt is the write address
// READOUT  | streaming entries 0..wr_cnt-1 to the detector
// FINISH   | one-cycle frame_done pulse
module scaler_sequencer #(
  parameter int X_START = 160,
  parameter int X_END   = 1120,
  parameter int STEP    = 47,
  parameter int DEPTH   = 400
`ifdef SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 2000000
`endif
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        cam_captured,
  input  logic [15:0] X_Cont,
  input  logic [15:0] Y_Cont,
  output logic        scl_captured,
  output logic        scl_write,
  output logic        scl_read,
  output logic [8:0]  scl_addr,
  input  logic        scl_done,
  input  logic [31:0] scl_x,
  input  logic [31:0] scl_y,
  input  logic [31:0] scl_z,
  scaler_sequencer_if.master det,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
`ifdef SEQ_TIMEOUT_EN
  , output logic      err_timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_CAPTURE, S_READOUT, S_FINISH
  } state_t;

  localparam int PW = $clog2(STEP);
  localparam logic [PW-1:0] PH_LAST = PW'(STEP - 1);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [15:0]   XS      = 16'(X_START);
  localparam logic [15:0]   XE      = 16'(X_END);
  localparam logic [8:0]    DEPTH_W = 9'(DEPTH);

  state_t        state, state_nxt;
  logic [PW-1:0] x_phase, y_phase, x_ph_cur, y_ph_cur;
  logic          x_zero_q, line_start, hit;
  logic [8:0]    wr_cnt, wr_cnt_nxt, rd_ptr;
  logic          start_acc, cap_hit, wr_room, rd_avail, out_acc, out_load;

  // Effective sampling phases for the current pixel and the resulting hit
  always_comb begin
    x_ph_cur   = (X_Cont == XS) ? '0 : x_phase;
    y_ph_cur   = (Y_Cont == 16'd0) ? '0 : y_phase;
    line_start = (X_Cont == 16'd0) && !x_zero_q;
    hit        = (X_Cont >= XS) && (X_Cont <= XE) &&
                 (x_ph_cur == '0) && (y_ph_cur == '0);
  end

  // Phase counters follow the raster in every state; y advances on the
  // first cycle of each line so a blanking interval at column 0 counts once
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_phase  <= '0;
      y_phase  <= '0;
      x_zero_q <= 1'b0;
    end else begin
      x_phase  <= (x_ph_cur == PH_LAST) ? '0 : x_ph_cur + PH_ONE;
      x_zero_q <= (X_Cont == 16'd0);
      if (Y_Cont == 16'd0)
        y_phase <= '0;
      else if (line_start)
        y_phase <= (y_phase == PH_LAST) ? '0 : y_phase + PH_ONE;
    end
  end

  // Write/read bookkeeping shared by the FSM and the datapath
  always_comb begin
    start_acc  = (state == S_IDLE) && start;
    cap_hit    = (state == S_CAPTURE) && hit;
    wr_room    = (wr_cnt < DEPTH_W);
    wr_cnt_nxt = (cap_hit && wr_room) ? wr_cnt + 9'd1 : wr_cnt;
    rd_avail   = (rd_ptr < wr_cnt);
    out_acc    = det.out_valid && det.out_ready;
    out_load   = (state == S_READOUT) && rd_avail &&
                 (!det.out_valid || det.out_ready);
  end

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_tc;

  assign tmo_tc = (tmo_cnt == 32'd0);

  // Watchdog: preloaded while armed, counts down through CAPTURE
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt     <= 32'd0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_ARM)
        tmo_cnt <= 32'(TIMEOUT - 1);
      else if ((state == S_CAPTURE) && !tmo_tc)
        tmo_cnt <= tmo_cnt - 32'd1;
      if (start_acc)
        err_timeout <= 1'b0;
      else if ((state == S_CAPTURE) && tmo_tc && !scl_done)
        err_timeout <= 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; a hit coincident with scl_done is already in wr_cnt_nxt
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_ARM;
      S_ARM:     if (cam_captured && (X_Cont == 16'd0) && (Y_Cont == 16'd0))
                   state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (scl_done)
          state_nxt = (wr_cnt_nxt != 9'd0) ? S_READOUT : S_FINISH;
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_tc)
          state_nxt = S_IDLE;
`endif
      end
      S_READOUT: if (out_acc && det.out_last) state_nxt = S_FINISH;
      S_FINISH:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs to the scaler and status
  always_comb begin
    scl_captured = 1'b0;
    scl_write    = 1'b0;
    scl_read     = 1'b0;
    scl_addr     = 9'd0;
    busy         = (state != S_IDLE);
    frame_done   = (state == S_FINISH);
    case (state)
      S_CAPTURE: begin
        scl_captured = 1'b1;
        scl_write    = 1'b1;
        scl_addr     = wr_cnt;
      end
      S_READOUT: begin
        scl_read = 1'b1;
        scl_addr = rd_ptr;
      end
      default: ;
    endcase
  end

  // Write counter and sticky overflow; saturate at DEPTH instead of wrapping
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_cnt   <= 9'd0;
      overflow <= 1'b0;
    end else if (start_acc) begin
      wr_cnt   <= 9'd0;
      overflow <= 1'b0;
    end else begin
      wr_cnt <= wr_cnt_nxt;
      if (cap_hit && !wr_room) overflow <= 1'b1;
    end
  end

  // Read pointer advances once per sample loaded into the output register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)      rd_ptr <= 9'd0;
    else if (start_acc) rd_ptr <= 9'd0;
    else if (out_load)  rd_ptr <= rd_ptr + 9'd1;
  end

  // Output register: reload on free slot or acceptance, drop valid when drained
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      det.out_x     <= 32'd0;
      det.out_y     <= 32'd0;
      det.out_z     <= 32'd0;
      det.out_valid <= 1'b0;
      det.out_last  <= 1'b0;
    end else if (out_load) begin
      det.out_x     <= scl_x;
      det.out_y     <= scl_y;
      det.out_z     <= scl_z;
      det.out_valid <= 1'b1;
      det.out_last  <= (rd_ptr == wr_cnt - 9'd1);
    end else if (out_acc) begin
      det.out_valid <= 1'b0;
      det.out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scaler_sequencer.sv
// tb_scaler_sequencer: randomized frames with a scoreboard. The stimulus
// side computes the expected sample list from the sampling rules; a monitor
// pops and compares on every accepted output beat.
module tb_scaler_sequencer;

  localparam int XS = 160, XE = 1120, STEP = 47, DEPTH = 400;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        start, cam_captured, scl_done;
  logic [15:0] X_Cont, Y_Cont;
  logic        scl_captured, scl_write, scl_read;
  logic [8:0]  scl_addr;
  logic [31:0] scl_x, scl_y, scl_z;
  logic        busy, frame_done, overflow;
`ifdef SEQ_TIMEOUT_EN
  logic        err_timeout;
`endif

  scaler_sequencer_if det_if ();

  scaler_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .cam_captured(cam_captured),
    .X_Cont(X_Cont), .Y_Cont(Y_Cont), .scl_captured(scl_captured),
    .scl_write(scl_write), .scl_read(scl_read), .scl_addr(scl_addr),
    .scl_done(scl_done), .scl_x(scl_x), .scl_y(scl_y), .scl_z(scl_z),
    .det(det_if), .busy(busy), .frame_done(frame_done), .overflow(overflow)
`ifdef SEQ_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] x, y, z; logic last; } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;
  int fd_cnt = 0, acc_cnt = 0, rdy_mode = 0;
  logic [31:0] salt = 32'h0;

  function automatic exp_t mem_word(input logic [31:0] s, input logic [8:0] a);
    exp_t e;
    e.x = s ^ ({23'd0, a} * 32'h9E3779B1);
    e.y = ~e.x + {23'd0, a};
    e.z = {e.x[15:0], e.x[31:16]} ^ 32'h5A5A0000;
    e.last = 1'b0;
    return e;
  endfunction

  // Scaler buffer model: read data is a pure function of address and frame salt
  always_comb begin
    exp_t w;
    w = mem_word(salt, scl_addr);
    scl_x = w.x;
    scl_y = w.y;
    scl_z = w.z;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Detector ready pattern: 0 always ready, 1 toggling, 2 random
  initial begin
    det_if.out_ready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        0:       det_if.out_ready = 1'b1;
        1:       det_if.out_ready = ~det_if.out_ready;
        default: det_if.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares accepted beats, stall stability and frame_done timing
  initial begin
    bit stall_q = 0, fd_pend = 0;
    logic [31:0] hx = 0, hy = 0, hz = 0;
    logic hl = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        stall_q = 0;
        fd_pend = 0;
      end else begin
        if (fd_pend) begin
          chk("frame_done_after_last", 32'(frame_done), 32'd1);
          fd_pend = 0;
        end
        if (frame_done) fd_cnt++;
        if (stall_q) begin
          chk("stall_valid_held", 32'(det_if.out_valid), 32'd1);
          chk("stall_x_stable", det_if.out_x, hx);
          chk("stall_z_stable", det_if.out_z, hz);
          chk("stall_last_stable", 32'(det_if.out_last), 32'(hl));
          hy = hy;
        end
        if (det_if.out_valid && sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got out_valid=1 expected no sample pending");
        end else if (det_if.out_valid && det_if.out_ready) begin
          e = sb.pop_front();
          chk("out_x", det_if.out_x, e.x);
          chk("out_y", det_if.out_y, e.y);
          chk("out_z", det_if.out_z, e.z);
          chk("out_last", 32'(det_if.out_last), 32'(e.last));
          acc_cnt++;
          if (e.last) fd_pend = 1;
        end
        stall_q = det_if.out_valid && !det_if.out_ready;
        hx = det_if.out_x;
        hy = det_if.out_y;
        hz = det_if.out_z;
        hl = det_if.out_last;
      end
    end
  end

  task automatic pix(input int x, input int y, input bit st, input bit dn);
    X_Cont   = 16'(x);
    Y_Cont   = 16'(y);
    start    = st;
    scl_done = dn;
    @(posedge CLK); #1;
  endtask

  // One frame: sampled rows are full length, other rows are 2-pixel lines
  task automatic run_frame(input string tag, input int nrows, input int full_len,
                           input bit done_on_last, input bit pulse_start,
                           input int rdy, input int rst_at);
    int hits = 0, n, len, k;
    bit pulsed = 0;
    exp_t e;
    rdy_mode = rdy;
    salt     = $urandom;
    fd_cnt   = 0;
    acc_cnt  = 0;
    for (int r = 0; r < nrows; r++) begin
      len = (r % STEP == 0) ? full_len : 2;
      for (int x = 0; x < len; x++)
        if (r % STEP == 0 && x >= XS && x <= XE && (x - XS) % STEP == 0) hits++;
    end
    n = (hits > DEPTH) ? DEPTH : hits;
    for (int i = 0; i < n; i++) begin
      e = mem_word(salt, 9'(i));
      e.last = (i == n - 1);
      sb.push_back(e);
    end
    pix(0, 0, 1'b1, 1'b0);
    for (int x = 1; x <= 300; x++) pix(x, 0, 1'b0, 1'b0);
    pix(0, 0, 1'b0, 1'b0);
    pix(0, 0, 1'b0, 1'b0);
    for (int r = 0; r < nrows; r++) begin
      len = (r % STEP == 0) ? full_len : 2;
      for (int x = 0; x < len; x++)
        pix(x, r, pulse_start && r == nrows - 1 && x == 1,
            done_on_last && r == nrows - 1 && x == len - 1);
    end
    if (!done_on_last) begin
      X_Cont = 16'd0; Y_Cont = 16'd0; start = 1'b0; scl_done = 1'b0;
      @(negedge CLK);
      chk({tag, "_wr_addr"}, 32'(scl_addr), 32'(n));
      chk({tag, "_scl_write"}, 32'(scl_write), 32'd1);
      chk({tag, "_scl_captured"}, 32'(scl_captured), 32'd1);
      @(posedge CLK); #1;
      pix(0, 0, 1'b0, 1'b1);
    end
    X_Cont = 16'd0; Y_Cont = 16'd0; start = 1'b0; scl_done = 1'b0;
    for (k = 0; k < 4000; k++) begin
      @(negedge CLK);
      if (!busy) break;
      if (rst_at >= 0 && acc_cnt >= rst_at) break;
      if (pulse_start && !pulsed && scl_read) begin
        start = 1'b1;
        pulsed = 1;
      end else start = 1'b0;
    end
    start = 1'b0;
    if (k >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: busy still 1 after 4000 cycles, required 0", tag);
    end
    if (rst_at >= 0) begin
      RESET_N = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_out_valid", 32'(det_if.out_valid), 32'd0);
      chk("rst_out_last", 32'(det_if.out_last), 32'd0);
      chk("rst_out_x", det_if.out_x, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_scl_read", 32'(scl_read), 32'd0);
      chk("rst_scl_addr", 32'(scl_addr), 32'd0);
      sb.delete();
      repeat (2) @(posedge CLK);
      #1 RESET_N = 1'b1;
      @(posedge CLK); #1;
      return;
    end
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'(hits > DEPTH));
    chk({tag, "_frame_done_cnt"}, 32'(fd_cnt), 32'd1);
    chk({tag, "_valid_low"}, 32'(det_if.out_valid), 32'd0);
    sb.delete();
    @(posedge CLK); #1;
  endtask

  initial begin
    RESET_N = 1'b0; start = 1'b0; cam_captured = 1'b1; scl_done = 1'b0;
    X_Cont = 16'd0; Y_Cont = 16'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(det_if.out_valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_scl_ctrl", {29'd0, scl_captured, scl_write, scl_read}, 32'd0);
    chk("reset_scl_addr", 32'(scl_addr), 32'd0);
    @(posedge CLK); #1 RESET_N = 1'b1;
    @(posedge CLK); #1;

    run_frame("two_row", 2, 1200, 1'b0, 1'b1, 0, -1);
    run_frame("toggle", 2, 1200, 1'b0, 1'b0, 1, -1);
    run_frame("zero_hit", 1, 100, 1'b0, 1'b0, 0, -1);
    run_frame("coincident", 1, 1101, 1'b1, 1'b0, 2, -1);
    run_frame("reset_mid", 1, 1200, 1'b0, 1'b0, 0, 10);
    run_frame("after_reset", 2, 1200, 1'b0, 1'b0, 2, -1);
    run_frame("full", 960, 1200, 1'b0, 1'b1, 0, -1);
    run_frame("random", 50 + int'($urandom_range(0, 150)), 1200, 1'b0, 1'b0, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
